shift_seq_ctrl: RTL and testbench

- Multi-pass sequencer that sits directly upstream of the 4-bit combinational logical barrel shifter, which is limited to shifts of 0..3.
- Accepts a shift request of up to 2^AMT_W-1 positions over a valid/ready handshake.
- Feeds the shifter one pass per clock (step of at most 3) and accumulates the result in a register.
- Presents the final word to the downstream consumer over a second valid/ready handshake.

---
 rtl/shift_seq_ctrl_pkg.sv | 17 +
 rtl/shift_seq_ctrl_shifter.sv | 32 +++
 rtl/shift_seq_ctrl.sv | 99 +++++++++
 tb/tb_shift_seq_ctrl.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/shift_seq_ctrl_pkg.sv
// Shared types and constants for the multi-pass shift sequencer and the
// 4-bit logical barrel shifter it drives.
package shift_seq_ctrl_pkg;

  localparam int DATA_W   = 4;
  localparam int MAX_STEP = 3;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage : shift_seq_ctrl_pkg

// File: rtl/shift_seq_ctrl_shifter.sv
// 4-bit combinational logical barrel shifter, shift amount 0..3, zero fill.
// Two mux stages: shift by 1, then by 2.
module barrel_shifter_logical
  import shift_seq_ctrl_pkg::*;
(
  input  logic [DATA_W-1:0] din,
  input  logic [1:0]        sh_amt,
  input  logic              dir,
  output logic [DATA_W-1:0] dout
);

  logic [DATA_W-1:0] stage1;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned and no latch is inferred.
    stage1 = din;
    dout   = din;

    if (sh_amt[0]) begin
      stage1 = (dir == DIR_RIGHT) ? {1'b0, din[DATA_W-1:1]}
                                  : {din[DATA_W-2:0], 1'b0};
    end

    dout = stage1;
    if (sh_amt[1]) begin
      dout = (dir == DIR_RIGHT) ? {2'b00, stage1[DATA_W-1:2]}
                                : {stage1[DATA_W-3:0], 2'b00};
    end
  end

endmodule : barrel_shifter_logical

// File: rtl/shift_seq_ctrl.sv
// Multi-pass sequencer: breaks a shift request of up to 2^AMT_W-1 positions
// into passes of at most MAX_STEP through the 0..3 barrel shifter.
module shift_seq_ctrl
  import shift_seq_ctrl_pkg::*;
#(
  parameter int AMT_W    = 3,
  parameter int MAX_STEP = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] din,
  input  logic [AMT_W-1:0]  amt,
  input  logic              dir,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] dout,
  output logic              busy
);

  localparam logic [AMT_W-1:0] STEP_CAP = AMT_W'(MAX_STEP);

  state_t            state_q, state_d;
  logic [DATA_W-1:0] acc_q;
  logic [AMT_W-1:0]  rem_q;
  logic              dir_q;

  logic [AMT_W-1:0]  step;
  logic              last_pass;
  logic [DATA_W-1:0] pass_out;

  // Step never exceeds rem_q, so rem_q - step cannot underflow.
  assign step      = (rem_q > STEP_CAP) ? STEP_CAP : rem_q;
  assign last_pass = (rem_q <= STEP_CAP);

  barrel_shifter_logical u_shifter (
    .din    (acc_q),
    .sh_amt (step[1:0]),
    .dir    (dir_q),
    .dout   (pass_out)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = (amt == '0) ? DONE : SHIFT;
      SHIFT:   if (last_pass) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic; in_ready is held low for as long as reset is asserted.
  always_comb begin
    in_ready  = (state_q == IDLE) && !rst;
    out_valid = (state_q == DONE);
    busy      = (state_q == SHIFT) || (state_q == DONE);
  end

  // Datapath: capture in IDLE, one shifter pass per cycle in SHIFT, hold in DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: these are a handful of flops, not a memory, so clearing them on
      // reset is cheap and makes dout a known 0 straight out of reset.
      acc_q <= '0;
      rem_q <= '0;
      dir_q <= DIR_LEFT;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            acc_q <= din;
            rem_q <= amt;
            dir_q <= dir;
          end
        end
        SHIFT: begin
          acc_q <= pass_out;
          rem_q <= rem_q - step;
        end
        default: ;
      endcase
    end
  end

  // Result is the registered accumulator; no combinational path from din.
  assign dout = acc_q;

endmodule : shift_seq_ctrl

// File: tb/tb_shift_seq_ctrl.sv
// Self-checking bench for shift_seq_ctrl: directed table, hand-written
// backpressure/reset sequences, and a full din x amt x dir sweep.
module tb_shift_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] din;
  logic [2:0] amt;
  logic       dir;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] dout;
  logic       busy;

  int n_vec  = 0;
  int n_fail = 0;

  shift_seq_ctrl #(.AMT_W(3), .MAX_STEP(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .din       (din),
    .amt       (amt),
    .dir       (dir),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .dout      (dout),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [3:0] din;
    logic [2:0] amt;
    logic       dir;
    logic [3:0] exp_dout;
    int         exp_lat;
  } vec_t;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference: the whole shift done at once, zero fill, truncated to 4 bits.
  function automatic logic [3:0] ref_shift(input logic [3:0] d, input int a, input logic r);
    int v;
    v = int'(d);
    if (r) v = v >> a;
    else   v = (v << a) & 15;
    return v[3:0];
  endfunction

  function automatic int ref_lat(input int a);
    return (a + 2) / 3;
  endfunction

  // Issues one request, measures edges from accept to out_valid, drains it.
  task automatic do_req(input string name, input logic [3:0] d, input logic [2:0] a,
                        input logic r, input logic [3:0] exp_d, input int exp_lat,
                        input bit rand_ready);
    int n;
    int bcnt;
    @(negedge clk);
    din = d; amt = a; dir = r; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      check({name, "_accept_timeout"}, 0, 1);
      in_valid = 1'b0;
      return;
    end
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    bcnt = 0;
    forever begin
      bcnt += int'(busy);
      if (out_valid || n >= 20) break;
      @(negedge clk);
      n++;
    end
    check({name, "_latency"}, n, exp_lat);
    check({name, "_dout"}, dout, exp_d);
    out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    n = 0;
    while (!out_ready && n < 20) begin
      @(negedge clk);
      bcnt += int'(busy);
      check({name, "_hold_valid"}, out_valid, 1);
      check({name, "_hold_dout"}, dout, exp_d);
      out_ready = 1'($urandom_range(0, 1));
      n++;
    end
    out_ready = 1'b1;
    @(negedge clk);
    check({name, "_idle_ready"}, in_ready, 1);
    check({name, "_idle_valid"}, out_valid, 0);
    check({name, "_idle_busy"}, busy, 0);
    if (!rand_ready) check({name, "_busy_cycles"}, bcnt, exp_lat + 1);
  endtask

  initial begin
    vec_t tbl[$];
    tbl.push_back('{"zero_shift",  4'b1011, 3'd0, 1'b0, 4'b1011, 0});
    tbl.push_back('{"single_right",4'b1011, 3'd1, 1'b1, 4'b0101, 1});
    tbl.push_back('{"left_7",      4'b0001, 3'd7, 1'b0, 4'b0000, 3});
    tbl.push_back('{"right_5",     4'b1111, 3'd5, 1'b1, 4'b0000, 2});
    tbl.push_back('{"right_2",     4'b1100, 3'd2, 1'b1, 4'b0011, 1});
    tbl.push_back('{"left_3",      4'b0011, 3'd3, 1'b0, 4'b1000, 1});
    tbl.push_back('{"right_4",     4'b1001, 3'd4, 1'b1, 4'b0000, 2});
    tbl.push_back('{"left_6",      4'b0110, 3'd6, 1'b0, 4'b0000, 2});

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    din = '0; amt = '0; dir = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_in_ready", in_ready, 0);
    check("reset_out_valid", out_valid, 0);
    check("reset_dout", dout, 0);
    check("reset_busy", busy, 0);
    rst = 1'b0;
    #1;
    check("release_in_ready", in_ready, 1);

    out_ready = 1'b1;
    foreach (tbl[i])
      do_req(tbl[i].name, tbl[i].din, tbl[i].amt, tbl[i].dir,
             tbl[i].exp_dout, tbl[i].exp_lat, 1'b0);

    // Backpressure, with a second request offered while the result is held.
    @(negedge clk);
    din = 4'b0110; amt = 3'd1; dir = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    din = 4'b1111; amt = 3'd0;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      check("bp_out_valid", out_valid, 1);
      check("bp_dout", dout, 4'b1100);
      check("bp_in_ready", in_ready, 0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_idle", in_ready, 1);
    check("bp_release_valid", out_valid, 0);
    check("bp_release_dout", dout, 4'b1100);
    @(negedge clk);
    in_valid = 1'b0;
    check("bp_second_valid", out_valid, 1);
    check("bp_second_dout", dout, 4'b1111);
    @(negedge clk);
    check("bp_second_idle", in_ready, 1);

    // Reset during the second pass of a 7-position shift.
    @(negedge clk);
    din = 4'b0001; amt = 3'd7; dir = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    check("mid_busy_before_rst", busy, 1);
    rst = 1'b1;
    #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_dout", dout, 0);
    check("mid_rst_in_ready", in_ready, 0);
    check("mid_rst_busy", busy, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("mid_release_in_ready", in_ready, 1);
    do_req("after_rst", 4'b1010, 3'd2, 1'b1, 4'b0010, 1, 1'b0);

    // Full sweep against the reference model with random backpressure.
    for (int d = 0; d < 16; d++)
      for (int a = 0; a < 8; a++)
        for (int r = 0; r < 2; r++)
          do_req("sweep", 4'(d), 3'(a), 1'(r),
                 ref_shift(4'(d), a, 1'(r)), ref_lat(a), 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule : tb_shift_seq_ctrl
